// File: rtl/lc3_mem_arbiter.sv
// SLC-3 memory arbiter: shares one memory between the CPU and the program loader,
// one access in flight, fixed wait states. Define MEM_ARB_LOADER_PRIO_EN for loader-priority ties.
module lc3_mem_arbiter #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_ack,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic [DATA_W-1:0] l_rdata,
    output logic              l_ack,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              grant
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic                last_grant, last_grant_n;
    logic                cool, cool_n;
    logic                grant_n;
    logic                mem_ce_n, mem_we_n;
    logic [ADDR_W-1:0]   mem_addr_n;
    logic [DATA_W-1:0]   mem_wdata_n;
    logic [DATA_W-1:0]   c_rdata_n, l_rdata_n;
    logic                c_ack_n, l_ack_n, busy_n;
    logic                c_elig, l_elig, win;

    // The port served last is ineligible for the first IDLE cycle after DONE.
    assign c_elig = c_req && !(cool && (last_grant == 1'b0));
    assign l_elig = l_req && !(cool && (last_grant == 1'b1));

`ifdef MEM_ARB_LOADER_PRIO_EN
    assign win = l_elig;
`else
    assign win = (c_elig && l_elig) ? ~last_grant : l_elig;
`endif

    // State and registered outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            cool       <= 1'b0;
            grant      <= 1'b0;
            mem_ce     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            c_rdata    <= '0;
            l_rdata    <= '0;
            c_ack      <= 1'b0;
            l_ack      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            last_grant <= last_grant_n;
            cool       <= cool_n;
            grant      <= grant_n;
            mem_ce     <= mem_ce_n;
            mem_we     <= mem_we_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
            c_rdata    <= c_rdata_n;
            l_rdata    <= l_rdata_n;
            c_ack      <= c_ack_n;
            l_ack      <= l_ack_n;
            busy       <= busy_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        last_grant_n = last_grant;
        cool_n       = cool;
        grant_n      = grant;
        mem_ce_n     = mem_ce;
        mem_we_n     = mem_we;
        mem_addr_n   = mem_addr;
        mem_wdata_n  = mem_wdata;
        c_rdata_n    = c_rdata;
        l_rdata_n    = l_rdata;
        c_ack_n      = 1'b0;
        l_ack_n      = 1'b0;
        busy_n       = busy;

        case (state)
            IDLE: begin
                cool_n = 1'b0;
                if (c_elig || l_elig) begin
                    grant_n     = win;
                    cnt_n       = CNT_W'(WAIT_STATES);
                    mem_ce_n    = 1'b1;
                    mem_we_n    = win ? l_we    : c_we;
                    mem_addr_n  = win ? l_addr  : c_addr;
                    mem_wdata_n = win ? l_wdata : c_wdata;
                    busy_n      = 1'b1;
                    state_n     = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CNT_W'(1);
                end else begin
                    if (!mem_we) begin
                        if (grant) l_rdata_n = mem_rdata;
                        else       c_rdata_n = mem_rdata;
                    end
                    mem_ce_n = 1'b0;
                    mem_we_n = 1'b0;
                    c_ack_n  = ~grant;
                    l_ack_n  = grant;
                    state_n  = DONE;
                end
            end
            DONE: begin
                last_grant_n = grant;
                cool_n       = 1'b1;
                busy_n       = 1'b0;
                state_n      = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Scoreboard bench for lc3_mem_arbiter: expected accesses are queued when requests
// are driven and retired against the memory bus and the ack pulses.
module tb_lc3_mem_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned WS = 1;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          c_req = 1'b0, c_we = 1'b0;
    logic [AW-1:0] c_addr = '0;
    logic [DW-1:0] c_wdata = '0;
    logic [DW-1:0] c_rdata;
    logic          c_ack;
    logic          l_req = 1'b0, l_we = 1'b0;
    logic [AW-1:0] l_addr = '0;
    logic [DW-1:0] l_wdata = '0;
    logic [DW-1:0] l_rdata;
    logic          l_ack;
    logic          mem_ce, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy, grant;

    lc3_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(WS)) dut (
        .Clk(Clk), .Reset(Reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .c_ack(c_ack),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_rdata(l_rdata), .l_ack(l_ack),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .grant(grant)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic          port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   ce_cyc = 0;
    int   acc_ce = 0;
    int   last_ack_cyc = -1;
    bit   gap_chk = 0;
    bit   quiet = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        else n_pass++;
    endtask

    function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
        return (a == 16'h0005) ? 16'h1234 : ((a ^ 16'h3C3C) + 16'h0101);
    endfunction

    // Memory data is only meaningful on the last ACCESS cycle.
    assign mem_rdata = (mem_ce && ce_cyc == int'(WS)) ? mem_model(mem_addr) : 16'hDEAD;

    always @(posedge Clk) begin
        cyc <= cyc + 1;
        ce_cyc <= mem_ce ? ce_cyc + 1 : 0;
    end

    always @(negedge Clk) begin
        check("busy", 32'(busy), 32'(mem_ce | c_ack | l_ack));
        if (mem_ce && !quiet) begin
            if (sb.size() == 0) begin
                check("unexpected_ce", 32'(1), 32'(0));
            end else begin
                check("grant", 32'(grant), 32'(sb[0].port));
                check("mem_addr", 32'(mem_addr), 32'(sb[0].addr));
                check("mem_we", 32'(mem_we), 32'(sb[0].we));
                if (sb[0].we) check("mem_wdata", 32'(mem_wdata), 32'(sb[0].wdata));
                acc_ce++;
            end
        end
        if (c_ack || l_ack) begin
            if (c_ack && l_ack) check("dual_ack", 32'(1), 32'(0));
            if (sb.size() == 0) begin
                check("unexpected_ack", 32'(1), 32'(0));
            end else begin
                e = sb.pop_front();
                check("ack_port", 32'(l_ack), 32'(e.port));
                check("rdata", 32'(e.port ? l_rdata : c_rdata), 32'(e.rdata));
                check("ce_cycles", 32'(acc_ce), 32'(WS + 1));
                if (gap_chk && last_ack_cyc >= 0)
                    check("ack_gap", 32'(cyc - last_ack_cyc), 32'(WS + 3));
                last_ack_cyc = cyc;
            end
            acc_ce = 0;
        end
    end

    task automatic push(input logic port, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] rd);
        exp_t x;
        x.port = port; x.we = we; x.addr = a; x.wdata = d; x.rdata = rd;
        sb.push_back(x);
    endtask

    // Holds a request until its ack, returning cycles from drive to ack.
    task automatic op(input logic port, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input bit drop, output int lat);
        int c0;
        int n;
        if (port) begin l_we = we; l_addr = a; l_wdata = d; l_req = 1'b1; end
        else      begin c_we = we; c_addr = a; c_wdata = d; c_req = 1'b1; end
        c0 = cyc;
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!(port ? l_ack : c_ack) && n < 50);
        if (!(port ? l_ack : c_ack)) check("ack_timeout", 32'(0), 32'(1));
        lat = cyc - c0;
        if (drop) begin
            if (port) l_req = 1'b0;
            else      c_req = 1'b0;
        end
    endtask

    task automatic pulse_reset();
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    logic first;
    int lat;

    initial begin
        repeat (3) @(negedge Clk);
        check("rst_mem_ce", 32'(mem_ce), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_grant", 32'(grant), 32'(0));
        check("rst_acks", 32'({c_ack, l_ack}), 32'(0));
        check("rst_c_rdata", 32'(c_rdata), 32'(0));
        check("rst_l_rdata", 32'(l_rdata), 32'(0));
        Reset = 1'b0;
        @(negedge Clk);

        // Single CPU read.
        push(1'b0, 1'b0, 16'h0005, 16'h0000, 16'h1234);
        op(1'b0, 1'b0, 16'h0005, 16'h0000, 1'b1, lat);
        check("read_latency", 32'(lat), 32'(WS + 2));
        repeat (2) @(negedge Clk);

        // Loader write leaves both rdata registers alone.
        push(1'b1, 1'b1, 16'h0030, 16'h5A5A, 16'h0000);
        op(1'b1, 1'b1, 16'h0030, 16'h5A5A, 1'b1, lat);
        check("write_latency", 32'(lat), 32'(WS + 2));
        check("l_rdata_hold", 32'(l_rdata), 32'(0));
        check("c_rdata_hold", 32'(c_rdata), 32'(16'h1234));
        repeat (2) @(negedge Clk);

        // CPU write, then a read at the top of the address space.
        push(1'b0, 1'b1, 16'h0040, 16'hBEEF, 16'h1234);
        op(1'b0, 1'b1, 16'h0040, 16'hBEEF, 1'b1, lat);
        push(1'b0, 1'b0, 16'hFFFF, 16'h0000, mem_model(16'hFFFF));
        op(1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b1, lat);
        repeat (2) @(negedge Clk);

        // Back-to-back CPU reads with req held across the ack.
        push(1'b0, 1'b0, 16'h0100, 16'h0000, mem_model(16'h0100));
        push(1'b0, 1'b0, 16'h0101, 16'h0000, mem_model(16'h0101));
        op(1'b0, 1'b0, 16'h0100, 16'h0000, 1'b0, lat);
        op(1'b0, 1'b0, 16'h0101, 16'h0000, 1'b1, lat);
        check("b2b_latency", 32'(lat), 32'(WS + 4));
        repeat (2) @(negedge Clk);

        // Both ports requesting continuously from a fresh reset.
        pulse_reset();
`ifdef MEM_ARB_LOADER_PRIO_EN
        first = 1'b1;
`else
        first = 1'b0;
`endif
        for (int k = 0; k < 4; k++) begin
            if ((first ^ k[0]) == 1'b0)
                push(1'b0, 1'b0, 16'h0010 + 16'(k / 2), 16'h0000, mem_model(16'h0010 + 16'(k / 2)));
            else
                push(1'b1, 1'b0, 16'h0020 + 16'(k / 2), 16'h0000, mem_model(16'h0020 + 16'(k / 2)));
        end
        gap_chk = 1'b1;
        last_ack_cyc = -1;
        fork
            begin
                int lc;
                op(1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, lc);
                op(1'b0, 1'b0, 16'h0011, 16'h0000, 1'b1, lc);
            end
            begin
                int ll;
                op(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, ll);
                op(1'b1, 1'b0, 16'h0021, 16'h0000, 1'b1, ll);
            end
        join
        gap_chk = 1'b0;
        repeat (3) @(negedge Clk);

        // Reset in the middle of an access abandons it.
        quiet = 1'b1;
        c_we = 1'b0; c_addr = 16'h0050; c_req = 1'b1;
        @(negedge Clk);
        check("mid_pre_ce", 32'(mem_ce), 32'(1));
        #1 Reset = 1'b1;
        #1;
        check("mid_rst_ce", 32'(mem_ce), 32'(0));
        check("mid_rst_busy", 32'(busy), 32'(0));
        check("mid_rst_ack", 32'(c_ack), 32'(0));
        c_req = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        repeat (10) begin
            @(negedge Clk);
            check("post_rst_idle", 32'({c_ack, mem_ce, busy}), 32'(0));
        end
        quiet = 1'b0;

        check("sb_empty", 32'(sb.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
